operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
// - ID/operand-read stage between fetch and execute. Accepts {pc, instr} over valid/ready.
// - Extracts rs1/rs2/rd, drives the register-file read ports and merges same-cycle writeback.
// - Tracks in-flight destination registers in a scoreboard; stalls on RAW/WAW hazards.
// - Registers {pc, instr, rs1_val, rs2_val, rd} into the ID/EX pipeline register.
// PARAMETERS
// - XLEN    32  data/pc width
// - NREGS   32  architectural registers; scoreboard depth; index width $clog2(NREGS)
// PORTS
// - clk          in   1     clock; sole clock domain
// - rst_n        in   1     reset, asynchronous, active-low
// - in_valid     in   1     fetch offers an instruction
// - in_ready     out  1     stage accepts in this cycle
// - in_pc        in   XLEN  instruction address
// - in_instr     in   32    RV32I instruction word
// - rf_rs1_addr  out  5     regfile read address 1 (combinational from in_instr)
// - rf_rs2_addr  out  5     regfile read address 2
// - rf_rs1_data  in   XLEN  regfile read data 1 (combinational, x0 reads 0)
// - rf_rs2_data  in   XLEN  regfile read data 2
// - wb_we        in   1     writeback commits this cycle (same signals feed regfile write port)
// - wb_rd        in   5     writeback destination
// - wb_data      in   XLEN  writeback value
// - flush        in   1     kill ID/EX contents and block acceptance this cycle
// - ex_valid     out  1     ID/EX register holds an instruction
// - ex_ready     in   1     execute consumes it this cycle
// - ex_pc, ex_instr  out  XLEN/32  registered copies
// - ex_rs1_val, ex_rs2_val  out  XLEN  registered operands
// - ex_rd        out  5     registered destination (0 if no write)
// BEHAVIOUR
// - Reset: ex_valid=0, all ex_* outputs 0, scoreboard all clear. in_ready is combinational.
// - Decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
//   - uses_rs1: all opcodes except LUI, AUIPC, JAL.
//   - uses_rs2: BRANCH, STORE, OP.
//   - writes_rd: all except BRANCH, STORE. Unknown opcodes use/write nothing.
//   - rd=0 is never written.
// - pending(r): scoreboard bit r, forced 0 for r=0.
// - hazard = (uses_rs1 & pend_rs1) | (uses_rs2 & pend_rs2) | (writes_rd & pending(rd)).
//   - pend_rsX is the pending bit, masked to 0 when the WB merge path below clears it.
// - in_ready = !flush & !hazard & (!ex_valid | ex_ready). Issue = in_valid & in_ready.
// - Latency: 1 cycle from issue to ex_valid. Back-to-back issue when ex_ready is held high.
// - ex_valid holds with stable payload while ex_ready=0.
// - Operand merge: if wb_we & wb_rd==rsX & rsX!=0, rsX value = wb_data; else rf_rsX_data.
// - Scoreboard:
//   - set bit rd on issue when writes_rd & rd!=0.
//   - clear bit wb_rd on wb_we.
//   - same register set and cleared in the same cycle: set wins.
// - flush=1:
//   - next ex_valid=0; no issue this cycle.
//   - if ex_valid & ex_rd!=0, clear that scoreboard bit (entry never reaches writeback).
//   - wb clears still apply.
// - Pending writes beyond EX are unaffected by flush; execute/WB retire them normally.
// - Reset mid-operation: asynchronous return to reset state; partially stalled instruction is dropped.
// CONFIGURATION
// - OPF_WB_BYPASS_EN defined: same-cycle wb_we to a pending rsX clears the hazard and uses wb_data (0-cycle bubble).
// - OPF_WB_BYPASS_EN undefined:
//   - hazard uses raw scoreboard bits; a writing register stays hazardous that cycle.
//   - operand taken from rf_rsX_data the cycle after (1 extra bubble).
//   - Merge mux is absent.
// STRUCTURE
// - Package cpu_pkg:
//   - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP).
//   - typedef reg_idx_t (logic [4:0]) and decoded-use struct opf_use_t {uses_rs1, uses_rs2, writes_rd}.
// - Sub-module opf_scoreboard: NREGS-bit set/clear vector with set-wins rule and x0 forced clear.
// - Decode, merge and the ID/EX register live in operand_fetch.
// TESTING
// - Reset: rst_n low mid-stream -> ex_valid=0 same cycle, scoreboard clear; after release,
//   ADDI x1,x0,5 issues with in_ready=1.
// - RAW stall: issue ADDI x3 (ex_ready=1), then ADD x4,x3,x3 with wb_we=0 -> in_ready=0 until wb_we,
//   wb_rd=3, wb_data=0x2A. Then ex_rs1_val=ex_rs2_val=0x2A: issued same cycle with _EN, next cycle without.
// - WAW: pending x5, instr writing x5 -> stalled until wb_rd=5 clears the bit.
// - Back-pressure: ex_ready=0 for 3 cycles -> ex_* stable, in_ready=0; ex_ready=1 -> next instruction issues.
// - Flush: ex holds rd=7, flush=1 -> ex_valid=0 next cycle, bit 7 clear, in_ready=0 during flush.
// - x0/none: ADD x0,x1,x2 and SW -> no scoreboard bit set; LUI with pending rs1 field bits -> no stall.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared decode definitions for the operand-fetch stage: RV32I opcodes, register index type
// and the per-instruction operand/destination usage summary.
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } opf_use_t;

  // Unknown opcodes neither read nor write, so they can never stall or mark a register.
  function automatic opf_use_t decode_use(input logic [6:0] opc);
    opf_use_t u;
    u = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: u.writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        u.uses_rs1  = 1'b1;
        u.writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        u.uses_rs1  = 1'b1;
        u.uses_rs2  = 1'b1;
        u.writes_rd = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Fetch-side and execute-side valid/ready handshakes of the operand-fetch stage.
// master = fetch/execute neighbours, slave = operand_fetch.
interface operand_fetch_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_instr;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [4:0]      ex_rd;

  modport master (
    output in_valid, in_pc, in_instr, ex_ready,
    input  in_ready, ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd
  );

  modport slave (
    input  in_valid, in_pc, in_instr, ex_ready,
    output in_ready, ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd
  );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// In-flight destination tracker: one pending bit per register, set on issue,
// cleared by writeback or by a flushed ID/EX entry; set wins, x0 never pending.
module opf_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  reg_idx_t         set_idx,
  input  logic             clr_wb_en,
  input  reg_idx_t         clr_wb_idx,
  input  logic             clr_fl_en,
  input  reg_idx_t         clr_fl_idx,
  output logic [NREGS-1:0] pend
);

  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] pend_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en)    set_vec[set_idx]    = 1'b1;
    if (clr_wb_en) clr_vec[clr_wb_idx] = 1'b1;
    if (clr_fl_en) clr_vec[clr_fl_idx] = 1'b1;
    pend_nxt    = (pend & ~clr_vec) | set_vec;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// ID/operand-read stage: decode, hazard stall against the scoreboard, operand read and ID/EX register.
// OPF_WB_BYPASS_EN enables same-cycle writeback bypass into the operands and hazard check.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_fetch_if.slave   bus,
  output reg_idx_t         rf_rs1_addr,
  output reg_idx_t         rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             wb_we,
  input  reg_idx_t         wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush
);

  reg_idx_t         rs1, rs2, rd;
  opf_use_t         use_d;
  logic [NREGS-1:0] pend;
  logic             pend_rs1_raw, pend_rs2_raw, pend_rd;
  logic             pend_rs1, pend_rs2;
  logic [XLEN-1:0]  op_rs1, op_rs2;
  logic             hazard, in_ready, issue;
  reg_idx_t         rd_nxt;

  logic             ex_valid_q;
  logic [XLEN-1:0]  ex_pc_q;
  logic [31:0]      ex_instr_q;
  logic [XLEN-1:0]  ex_rs1_q, ex_rs2_q;
  reg_idx_t         ex_rd_q;

  assign rs1   = bus.in_instr[19:15];
  assign rs2   = bus.in_instr[24:20];
  assign rd    = bus.in_instr[11:7];
  assign use_d = decode_use(bus.in_instr[6:0]);

  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  assign pend_rs1_raw = (rs1 != '0) & pend[rs1];
  assign pend_rs2_raw = (rs2 != '0) & pend[rs2];
  assign pend_rd      = (rd  != '0) & pend[rd];

`ifdef OPF_WB_BYPASS_EN
  logic wb_hit_rs1, wb_hit_rs2;
  assign wb_hit_rs1 = wb_we & (wb_rd == rs1) & (rs1 != '0);
  assign wb_hit_rs2 = wb_we & (wb_rd == rs2) & (rs2 != '0);
  assign pend_rs1   = pend_rs1_raw & ~wb_hit_rs1;
  assign pend_rs2   = pend_rs2_raw & ~wb_hit_rs2;
  assign op_rs1     = wb_hit_rs1 ? wb_data : rf_rs1_data;
  assign op_rs2     = wb_hit_rs2 ? wb_data : rf_rs2_data;
`else
  // Without bypass the operand is picked up from the regfile the cycle after writeback.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign pend_rs1 = pend_rs1_raw;
  assign pend_rs2 = pend_rs2_raw;
  assign op_rs1   = rf_rs1_data;
  assign op_rs2   = rf_rs2_data;
`endif

  // WAW check uses the raw bit in both builds: the new write must not race the retiring one.
  assign hazard = (use_d.uses_rs1 & pend_rs1) |
                  (use_d.uses_rs2 & pend_rs2) |
                  (use_d.writes_rd & pend_rd);

  assign in_ready = ~flush & ~hazard & (~ex_valid_q | bus.ex_ready);
  assign issue    = bus.in_valid & in_ready;
  assign rd_nxt   = use_d.writes_rd ? rd : '0;

  opf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (issue & use_d.writes_rd & (rd != '0)),
    .set_idx    (rd),
    .clr_wb_en  (wb_we),
    .clr_wb_idx (wb_rd),
    .clr_fl_en  (flush & ex_valid_q & (ex_rd_q != '0)),
    .clr_fl_idx (ex_rd_q),
    .pend       (pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_instr_q <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      ex_pc_q    <= bus.in_pc;
      ex_instr_q <= bus.in_instr;
      ex_rs1_q   <= op_rs1;
      ex_rs2_q   <= op_rs2;
      ex_rd_q    <= rd_nxt;
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_instr   = ex_instr_q;
  assign bus.ex_rs1_val = ex_rs1_q;
  assign bus.ex_rs2_val = ex_rs2_q;
  assign bus.ex_rd      = ex_rd_q;

endmodule
